// File: rtl/one_hot_decoder_stream.sv
// Purpose: registered one-hot to binary index decoder with malformed-code flag and saturating error count.
// Latency: exactly 1 cycle from input accept to valid_o.
// Backpressure: ready_o = !valid_o || ready_i; a held output beat stalls the input, and no beat is dropped.
//
// Ports:
//   clk_i, rst_ni       clock (rising edge) and asynchronous active-low reset
//   code_i/valid_i      input beat; ready_o signals that the beat is accepted this cycle
//   value_o/err_o       decoded index and malformed flag; qualified by valid_o, consumed on ready_i
//   clr_err_i           synchronous clear of err_cnt_o (wins over a simultaneous increment)
//   err_cnt_o           saturating count of accepted malformed beats
module one_hot_decoder_stream #(
    parameter int INPUT_WIDTH   = 16,
    parameter int OUTPUT_WIDTH  = $clog2(INPUT_WIDTH),
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [INPUT_WIDTH-1:0]   code_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [OUTPUT_WIDTH-1:0]  value_o,
    output logic                     err_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    input  logic                     clr_err_i,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    logic                     valid_q, valid_d;
    logic [OUTPUT_WIDTH-1:0]  value_q, value_d;
    logic                     err_q, err_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                     accept;
    logic                     out_hs;
    logic [OUTPUT_WIDTH-1:0]  dec_idx;
    logic                     dec_err;

    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o;
    assign out_hs  = valid_q && ready_i;

    // Scanning from the top down leaves the lowest set index in dec_idx,
    // which is the reported index for multi-hot codes.
    always_comb begin
        dec_idx = '0;
        for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
            if (code_i[i]) begin
                dec_idx = OUTPUT_WIDTH'(i);
            end
        end
        // code & (code-1) clears the lowest set bit; anything left means multi-hot.
        dec_err = (code_i == '0) ||
                  ((code_i & (code_i - INPUT_WIDTH'(1))) != '0);
    end

    always_comb begin
        valid_d = valid_q;
        value_d = value_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        if (accept) begin
            valid_d = 1'b1;
            value_d = dec_idx;
            err_d   = dec_err;
        end else if (out_hs) begin
            valid_d = 1'b0;
        end

        if (clr_err_i) begin
            cnt_d = '0;
        end else if (accept && dec_err && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            value_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            value_q <= value_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o   = valid_q;
    assign value_o   = value_q;
    assign err_o     = err_q;
    assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_one_hot_decoder_stream.sv
// Bench for one_hot_decoder_stream: three instances sharing one stimulus stream
// (16-bit/8-bit counter, 16-bit/2-bit counter, 12-bit/8-bit counter), checked
// against a queue-based reference model of the stream contract.
module tb_one_hot_decoder_stream;

    logic        clk;
    logic        rst_n;
    logic [15:0] code_i;
    logic        valid_i;
    logic        ready_i;
    logic        clr_err_i;

    logic       rdy_a, vld_a, err_a;
    logic [3:0] val_a;
    logic [7:0] cnt_a_o;
    logic       rdy_b, vld_b, err_b;
    logic [3:0] val_b;
    logic [1:0] cnt_b_o;
    logic       rdy_c, vld_c, err_c;
    logic [3:0] val_c;
    logic [7:0] cnt_c_o;

    one_hot_decoder_stream #(.INPUT_WIDTH(16), .ERR_CNT_WIDTH(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .code_i(code_i), .valid_i(valid_i),
        .ready_o(rdy_a), .value_o(val_a), .err_o(err_a), .valid_o(vld_a),
        .ready_i(ready_i), .clr_err_i(clr_err_i), .err_cnt_o(cnt_a_o)
    );

    one_hot_decoder_stream #(.INPUT_WIDTH(16), .ERR_CNT_WIDTH(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .code_i(code_i), .valid_i(valid_i),
        .ready_o(rdy_b), .value_o(val_b), .err_o(err_b), .valid_o(vld_b),
        .ready_i(ready_i), .clr_err_i(clr_err_i), .err_cnt_o(cnt_b_o)
    );

    one_hot_decoder_stream #(.INPUT_WIDTH(12), .ERR_CNT_WIDTH(8)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .code_i(code_i[11:0]), .valid_i(valid_i),
        .ready_o(rdy_c), .value_o(val_c), .err_o(err_c), .valid_o(vld_c),
        .ready_i(ready_i), .clr_err_i(clr_err_i), .err_cnt_o(cnt_c_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit err;
    } beat_t;

    beat_t qa[$];   // pending output beats for the 16-bit instances
    beat_t qc[$];   // pending output beats for the 12-bit instance
    int    cnt_a, cnt_b, cnt_c;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: count set bits among the low w bits, remember the lowest.
    function automatic beat_t ref_decode(input logic [15:0] code, input int w);
        beat_t b;
        int    ones;
        ones  = 0;
        b.val = 0;
        for (int i = 0; i < w; i++) begin
            if (code[i]) begin
                if (ones == 0) b.val = i;
                ones++;
            end
        end
        b.err = (ones != 1);
        return b;
    endfunction

    function automatic int sat_inc(input int c, input int maxv);
        return (c + 1 > maxv) ? maxv : c + 1;
    endfunction

    task automatic check_outputs();
        chk("valid_a", vld_a, qa.size() != 0);
        chk("valid_b", vld_b, qa.size() != 0);
        chk("valid_c", vld_c, qc.size() != 0);
        if (qa.size() != 0) begin
            chk("value_a", val_a, qa[0].val);
            chk("err_a",   err_a, qa[0].err);
            chk("value_b", val_b, qa[0].val);
            chk("err_b",   err_b, qa[0].err);
        end
        if (qc.size() != 0) begin
            chk("value_c", val_c, qc[0].val);
            chk("err_c",   err_c, qc[0].err);
        end
        chk("cnt_a", cnt_a_o, cnt_a);
        chk("cnt_b", cnt_b_o, cnt_b);
        chk("cnt_c", cnt_c_o, cnt_c);
    endtask

    // One clock cycle: drive inputs just after an edge, check ready, advance the
    // model at the edge, then check the registered outputs just after it.
    task automatic cycle(input bit v, input logic [15:0] c, input bit r, input bit clr);
        bit    acc_a, acc_c, hs_a, hs_c;
        beat_t da, dc;
        valid_i   = v;
        code_i    = c;
        ready_i   = r;
        clr_err_i = clr;
        #1;
        chk("ready_a", rdy_a, (qa.size() == 0) || r);
        chk("ready_b", rdy_b, (qa.size() == 0) || r);
        chk("ready_c", rdy_c, (qc.size() == 0) || r);
        acc_a = v && ((qa.size() == 0) || r);
        acc_c = v && ((qc.size() == 0) || r);
        hs_a  = (qa.size() != 0) && r;
        hs_c  = (qc.size() != 0) && r;
        da    = ref_decode(c, 16);
        dc    = ref_decode(c, 12);
        @(posedge clk);
        if (hs_a) void'(qa.pop_front());
        if (hs_c) void'(qc.pop_front());
        if (acc_a) qa.push_back(da);
        if (acc_c) qc.push_back(dc);
        if (clr) begin
            cnt_a = 0;
            cnt_b = 0;
            cnt_c = 0;
        end else begin
            if (acc_a && da.err) cnt_a = sat_inc(cnt_a, 255);
            if (acc_a && da.err) cnt_b = sat_inc(cnt_b, 3);
            if (acc_c && dc.err) cnt_c = sat_inc(cnt_c, 255);
        end
        #1;
        check_outputs();
    endtask

    initial begin
        logic [15:0] rc;
        rst_n     = 1'b0;
        code_i    = '0;
        valid_i   = 1'b0;
        ready_i   = 1'b0;
        clr_err_i = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;

        // Reset state
        #12;
        chk("rst_valid", vld_a, 0);
        chk("rst_value", val_a, 0);
        chk("rst_err",   err_a, 0);
        chk("rst_cnt",   cnt_a_o, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back legal codes at full throughput
        cycle(1, 16'h0001, 1, 0);
        chk("b2b_v0", val_a, 0);
        cycle(1, 16'h0080, 1, 0);
        chk("b2b_v7", val_a, 7);
        cycle(1, 16'h8000, 1, 0);
        chk("b2b_v15", val_a, 15);
        chk("b2b_cnt", cnt_a_o, 0);
        cycle(0, 16'h0000, 1, 0);

        // Zero code and multi-hot code
        cycle(1, 16'h0000, 1, 0);
        chk("zero_err", err_a, 1);
        cycle(1, 16'h0110, 1, 0);
        chk("multi_val", val_a, 4);
        chk("multi_err", err_a, 1);
        cycle(0, 16'h0000, 1, 0);
        chk("malformed_cnt", cnt_a_o, 2);

        // Backpressure: beat 5 held while beat 10 waits on the input
        cycle(1, 16'h0020, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 16'h0400, 0, 0);
            chk("bp_ready", rdy_a, 0);
            chk("bp_hold", val_a, 5);
        end
        cycle(1, 16'h0400, 1, 0);
        chk("bp_next", val_a, 10);
        cycle(0, 16'h0000, 1, 0);
        chk("bp_drain", vld_a, 0);

        // Saturation of the 2-bit counter, then clear beating an increment
        for (int i = 0; i < 5; i++) cycle(1, 16'h0000, 1, 0);
        chk("sat_cnt_b", cnt_b_o, 3);
        cycle(1, 16'h0003, 1, 1);
        chk("clr_cnt_b", cnt_b_o, 0);
        chk("clr_cnt_a", cnt_a_o, 0);
        cycle(0, 16'h0000, 1, 0);

        // Top bit of the 12-bit instance
        cycle(1, 16'h0800, 1, 0);
        chk("w12_val", val_c, 11);
        chk("w12_err", err_c, 0);
        cycle(0, 16'h0000, 1, 0);

        // Randomised traffic with random backpressure and occasional clears
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       rc = 16'h0000;
                1:       rc = 16'($urandom);
                default: rc = 16'h0001 << $urandom_range(0, 15);
            endcase
            cycle($urandom_range(0, 3) != 0, rc, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0);
        end

        // Asynchronous reset between edges with a held beat and non-zero count
        cycle(1, 16'h0003, 0, 0);
        cycle(1, 16'h0003, 0, 0);
        chk("pre_rst_valid", vld_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", vld_a, 0);
        chk("arst_cnt", cnt_a_o, 0);
        chk("arst_ready", rdy_a, 1);
        qa.delete();
        qc.delete();
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        valid_i = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
        cycle(1, 16'h0004, 1, 0);
        chk("post_rst_val", val_a, 2);
        chk("post_rst_vld", vld_a, 1);
        cycle(0, 16'h0000, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
